soc_system_pwm_bank: RTL and testbench

Parametrised successor to the single 8-bit Avalon-MM output port that drives heater control. Provides NUM_CH independent PWM output channels behind one Avalon-MM slave.
- Per-channel duty registers with glitch-free period-boundary update.
- Shared programmable prescaler.
- Safety watchdog that forces every output low if software stops refreshing it.
- Sits in soc_system between the HPS lightweight bridge and the heater/fan MOSFET pins.

---
 rtl/soc_system_pwm_pkg.sv | 20 ++
 rtl/soc_system_pwm_wdt.sv | 57 +++++
 rtl/soc_system_pwm_bank.sv | 166 ++++++++++++++++
 tb/tb_soc_system_pwm_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pwm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// soc_system_pwm_pkg -- register map and bit indices of the PWM bank
// Rev 1.0
// ------------------------------------------------------------------
package soc_system_pwm_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_PRESC  = 1;
  localparam int ADDR_WDT    = 2;
  localparam int ADDR_STATUS = 3;
  localparam int ADDR_DUTY0  = 4;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_WDT_BIT  = 1;
  localparam int STAT_TRIP_BIT = 0;
  localparam int STAT_WRAP_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/soc_system_pwm_wdt.sv
`default_nettype none
// ------------------------------------------------------------------
// soc_system_pwm_wdt -- refresh watchdog: kick/load, decrement, trip
// Rev 1.0
// ------------------------------------------------------------------
module soc_system_pwm_wdt #(
  parameter int WDT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wdt_en,
  input  logic             kick,
  input  logic [WDT_W-1:0] kick_value,
  input  logic             clear_trip,
  output logic [WDT_W-1:0] count,
  output logic             tripped,
  output logic             trip
);

  logic [WDT_W-1:0] r_count;
  logic             r_tripped;
  logic             r_wdt_en_d;
  logic             w_at_one;
  logic             w_at_zero;

  assign w_at_one  = (r_count == WDT_W'(1));
  assign w_at_zero = (r_count == '0);

  // A kick always beats the expiring decrement; enabling on an empty
  // counter is treated as an immediate expiry.
  assign trip = wdt_en && !kick && (w_at_one || (w_at_zero && !r_wdt_en_d));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_tripped  <= 1'b0;
      r_wdt_en_d <= 1'b0;
    end else begin
      r_wdt_en_d <= wdt_en;
      if (kick) begin
        r_count <= kick_value;
      end else if (wdt_en && !w_at_zero) begin
        r_count <= r_count - WDT_W'(1);
      end
      if (trip) begin
        r_tripped <= 1'b1;
      end else if (clear_trip) begin
        r_tripped <= 1'b0;
      end
    end
  end

  assign count   = r_count;
  assign tripped = r_tripped;

endmodule
`default_nettype wire

// File: rtl/soc_system_pwm_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// soc_system_pwm_bank -- NUM_CH PWM channels behind an Avalon-MM slave
// Rev 1.0
// ------------------------------------------------------------------
module soc_system_pwm_bank
  import soc_system_pwm_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16,
  parameter int WDT_W   = 24,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              wdt_tripped
);

  localparam logic [PWM_W-1:0] C_CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [1:0]              r_ctrl;
  logic [PRESC_W-1:0]      r_presc;
  logic [PRESC_W-1:0]      r_presc_cnt;
  logic [PWM_W-1:0]        r_pwm_cnt;
  logic                    r_wrap_flag;

  logic                    w_wr;
  logic                    w_wr_ctrl;
  logic                    w_wr_presc;
  logic                    w_wr_wdt;
  logic                    w_wr_status;
  logic                    w_enable;
  logic                    w_tick;
  logic                    w_wrap;
  logic                    w_tripped;
  logic                    w_trip;
  logic [WDT_W-1:0]        w_wdt_count;
  logic [NUM_CH*PWM_W-1:0] w_duty_bus;
  logic                    w_unused_wdata;

  assign w_wr        = chipselect && !write_n;
  assign w_wr_ctrl   = w_wr && (address == ADDR_W'(ADDR_CTRL));
  assign w_wr_presc  = w_wr && (address == ADDR_W'(ADDR_PRESC));
  assign w_wr_wdt    = w_wr && (address == ADDR_W'(ADDR_WDT));
  assign w_wr_status = w_wr && (address == ADDR_W'(ADDR_STATUS));
  assign w_unused_wdata = ^writedata;

  assign w_enable = r_ctrl[CTRL_EN_BIT];
  assign w_tick   = w_enable && (r_presc_cnt == r_presc);
  assign w_wrap   = w_tick && (r_pwm_cnt == C_CNT_LAST);

  soc_system_pwm_wdt #(.WDT_W(WDT_W)) u_wdt (
    .clk        (clk),
    .reset_n    (reset_n),
    .wdt_en     (r_ctrl[CTRL_WDT_BIT]),
    .kick       (w_wr_wdt),
    .kick_value (writedata[WDT_W-1:0]),
    .clear_trip (w_wr_status && writedata[STAT_TRIP_BIT]),
    .count      (w_wdt_count),
    .tripped    (w_tripped),
    .trip       (w_trip)
  );

  // Enable cannot be set while tripped; a trip always drops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl  <= '0;
      r_presc <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl[CTRL_WDT_BIT] <= writedata[CTRL_WDT_BIT];
        if (!w_tripped) begin
          r_ctrl[CTRL_EN_BIT] <= writedata[CTRL_EN_BIT];
        end
      end
      if (w_trip) begin
        r_ctrl[CTRL_EN_BIT] <= 1'b0;
      end
      if (w_wr_presc) begin
        r_presc <= writedata[PRESC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_wrap_flag <= 1'b0;
    end else begin
      if (!w_enable || w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end
      if (!w_enable || w_wrap) begin
        r_pwm_cnt <= '0;
      end else if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end
      if (w_wrap) begin
        r_wrap_flag <= 1'b1;
      end else if (w_wr_status && writedata[STAT_WRAP_BIT]) begin
        r_wrap_flag <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] r_active;
    logic             r_out;
    logic             w_wr_duty;

    assign w_wr_duty = w_wr && (address == ADDR_W'(ADDR_DUTY0 + i));

    // The shadow reaches the comparator only at a period boundary.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_duty   <= '0;
        r_active <= '0;
        r_out    <= 1'b0;
      end else begin
        if (w_wr_duty) begin
          r_duty <= writedata[PWM_W-1:0];
        end
        if (!w_enable || w_wrap) begin
          r_active <= r_duty;
        end
        r_out <= w_enable && !w_tripped && (r_pwm_cnt < r_active);
      end
    end

    assign w_duty_bus[i*PWM_W +: PWM_W] = r_duty;
    assign pwm_out[i] = r_out;
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(ADDR_CTRL)) begin
      readdata = 32'(r_ctrl);
    end else if (address == ADDR_W'(ADDR_PRESC)) begin
      readdata = 32'(r_presc);
    end else if (address == ADDR_W'(ADDR_WDT)) begin
      readdata = 32'(w_wdt_count);
    end else if (address == ADDR_W'(ADDR_STATUS)) begin
      readdata = 32'({r_wrap_flag, w_tripped});
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(ADDR_DUTY0 + i)) begin
        readdata = 32'(w_duty_bus[i*PWM_W +: PWM_W]);
      end
    end
  end

  assign wdt_tripped = w_tripped;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pwm_bank.sv
`default_nettype none
// tb_soc_system_pwm_bank -- scoreboard bench; the reference model derives
// PWM phase from the number of enabled clocks rather than counter registers.
module tb_soc_system_pwm_bank;

  localparam int NUM_CH = 4;
  localparam int PWM_W  = 8;
  localparam int PERIOD = (1 << PWM_W) - 1;

  typedef struct {
    logic [NUM_CH-1:0] pwm;
    logic              trip;
    logic [31:0]       rd;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] pwm_out;
  logic              wdt_tripped;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // reference model state
  int          m_n;
  int          m_presc;
  int          m_wdt;
  int          m_duty[NUM_CH];
  int          m_active[NUM_CH];
  bit          m_en, m_wdt_en, m_wdt_en_prev, m_trip, m_wrap;
  bit [NUM_CH-1:0] m_out;

  soc_system_pwm_bank #(
    .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESC_W(16), .WDT_W(24), .ADDR_W(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pwm_out    (pwm_out),
    .wdt_tripped(wdt_tripped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("pwm_out", 32'(pwm_out), 32'(mon_e.pwm));
      check("wdt_tripped", 32'(wdt_tripped), 32'(mon_e.trip));
      check("readdata", readdata, mon_e.rd);
    end
  end

  task automatic model_reset();
    m_n = 0; m_presc = 0; m_wdt = 0;
    m_en = 0; m_wdt_en = 0; m_wdt_en_prev = 0; m_trip = 0; m_wrap = 0;
    m_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_duty[i] = 0;
      m_active[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input int addr);
    logic [31:0] v;
    v = '0;
    case (addr)
      0: v = {30'd0, m_wdt_en, m_en};
      1: v = 32'(m_presc);
      2: v = 32'(m_wdt);
      3: v = {30'd0, m_wrap, m_trip};
      default: if (addr - 4 < NUM_CH) v = 32'(m_duty[addr-4]);
    endcase
    return v;
  endfunction

  // True when the coming clock edge closes a PWM period.
  function automatic bit wrap_next();
    int k;
    k = m_n + 1;
    return m_en && (k % (m_presc + 1) == 0) && ((k / (m_presc + 1)) % PERIOD == 0);
  endfunction

  task automatic model_step(input bit wr, input int addr, input logic [31:0] d);
    int pos;
    bit wrap, kick, trip, en_n, wdt_en_n, trip_n;
    pos  = (m_n / (m_presc + 1)) % PERIOD;
    wrap = wrap_next();
    for (int i = 0; i < NUM_CH; i++) m_out[i] = m_en && !m_trip && (pos < m_active[i]);
    kick = wr && addr == 2;
    trip = m_wdt_en && !kick && (m_wdt == 1 || (m_wdt == 0 && !m_wdt_en_prev));
    for (int i = 0; i < NUM_CH; i++) if (!m_en || wrap) m_active[i] = m_duty[i];
    if (wrap) m_wrap = 1;
    else if (wr && addr == 3 && d[1]) m_wrap = 0;
    trip_n = trip ? 1'b1 : ((wr && addr == 3 && d[0]) ? 1'b0 : m_trip);
    if (kick) m_wdt = int'(d[23:0]);
    else if (m_wdt_en && m_wdt != 0) m_wdt = m_wdt - 1;
    en_n = m_en;
    wdt_en_n = m_wdt_en;
    if (wr && addr == 0) begin
      wdt_en_n = d[1];
      if (!m_trip) en_n = d[0];
    end
    if (trip) en_n = 0;
    m_n = m_en ? m_n + 1 : 0;
    if (wr && addr == 1) m_presc = int'(d[15:0]);
    if (wr && addr >= 4 && addr - 4 < NUM_CH) m_duty[addr-4] = int'(d[7:0]);
    m_wdt_en_prev = m_wdt_en;
    m_wdt_en = wdt_en_n;
    m_en = en_n;
    m_trip = trip_n;
  endtask

  // Drive one bus cycle, queue the expected view of this cycle, advance the model.
  task automatic cyc(input bit cs, input bit wn, input int addr, input logic [31:0] d);
    exp_t e;
    chipselect = cs;
    write_n = wn;
    address = 3'(addr);
    writedata = d;
    e.pwm = m_out;
    e.trip = m_trip;
    e.rd = model_read(addr);
    sb_q.push_back(e);
    @(posedge clk);
    model_step(cs && !wn, addr, d);
    #2;
  endtask

  task automatic wr(input int addr, input logic [31:0] d);
    cyc(1'b1, 1'b0, addr, d);
  endtask

  task automatic rd(input int addr);
    cyc(1'b1, 1'b1, addr, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
  endtask

  function automatic int pick_duty();
    case ($urandom_range(0, 4))
      0: return 0;
      1: return 1;
      2: return PERIOD - 1;
      3: return PERIOD;
      default: return int'($urandom_range(0, PERIOD));
    endcase
  endfunction

  initial begin
    int guard;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    for (int a = 0; a < 8; a++) rd(a);

    // ch0 at 64/255, prescale 0
    wr(4, 64); wr(1, 0); wr(0, 1);
    idle(3 * PERIOD);
    wr(5, 0); wr(6, PERIOD);
    idle(3 * PERIOD + 10);

    // mid-period duty change
    wr(0, 0); wr(4, 64); wr(3, 2); wr(0, 1);
    idle(99);
    wr(4, 200);
    idle(2 * PERIOD);
    rd(3); wr(3, 2); rd(3);

    // W1C of the wrap flag coinciding with a wrap
    guard = 0;
    while (!wrap_next() && guard < 2 * PERIOD) begin idle(1); guard++; end
    if (!wrap_next()) timeout("wrap alignment");
    wr(3, 2); rd(3); wr(3, 2); rd(3);

    // watchdog expiry and trip lockout
    wr(3, 3); wr(2, 50); wr(0, 3);
    idle(60);
    rd(0); wr(0, 3); rd(0); wr(3, 1); rd(0); rd(3);

    // kick in the cycle the counter would expire
    wr(2, 6); wr(0, 3);
    guard = 0;
    while (m_wdt != 1 && guard < 100) begin idle(1); guard++; end
    if (m_wdt != 1) timeout("wdt reaches one");
    wr(2, 50); rd(2); idle(3); rd(2); rd(3);

    // enabling the watchdog on an empty counter
    wr(0, 0); wr(2, 0); wr(0, 3); idle(3); rd(0); rd(3);
    wr(3, 3); wr(0, 1); idle(2);

    // asynchronous reset in the middle of a period
    wr(6, PERIOD); wr(0, 0); wr(0, 1); idle(40);
    reset_n = 1'b0;
    #1;
    check("async reset pwm_out", 32'(pwm_out), 32'd0);
    check("async reset readdata", readdata, 32'd0);
    #3 reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #2;

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) idle(1);
      else if (r < 75) wr(4 + int'($urandom_range(0, NUM_CH - 1)), 32'(pick_duty()));
      else if (r < 83) rd(int'($urandom_range(0, 7)));
      else if (r < 88) wr(0, {30'd0, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1) | 1)});
      else if (r < 93) wr(2, 32'($urandom_range(20, 600)));
      else if (r < 97) wr(3, 32'($urandom_range(0, 3)));
      else if (!m_en) wr(1, 32'($urandom_range(0, 3)));
      else idle(1);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
